neuron_seq_ctrl: RTL

NEURON_SEQ_CTRL -- requirements
Module: neuron_seq_ctrl

---
 rtl/neuron_seq_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/neuron_seq_ctrl.sv
// neuron_seq_ctrl: sequences one neuron evaluation. Streams N_INPUTS operand
// pairs into an external multiplier, gates its results into an external
// accumulator, maps the final sum onto a sigmoid LUT address and captures
// the activation.
// Ports: clk/rst (async, active-high); start/busy/done handshake;
//   in_idx/mac_valid/mac_ready drive the multiplier input side;
//   res_valid/acc_clr/acc_en/acc_data run the accumulator;
//   lut_addr/lut_data read the sigmoid LUT; output_neuron holds the result.
module neuron_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int N_INPUTS   = 16,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic [IDX_WIDTH-1:0]  in_idx,
  output logic                  mac_valid,
  input  logic                  mac_ready,
  input  logic                  res_valid,
  output logic                  acc_clr,
  output logic                  acc_en,
  input  logic [DATA_WIDTH-1:0] acc_data,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  input  logic [DATA_WIDTH-1:0] lut_data,
  output logic [DATA_WIDTH-1:0] output_neuron,
  output logic                  done
);

  // Counters need one extra bit so they can hold N_INPUTS itself.
  localparam int CW = IDX_WIDTH + 1;
  localparam logic [CW-1:0] N_CNT = CW'(N_INPUTS);
  localparam logic signed [DATA_WIDTH:0] BIAS = (DATA_WIDTH+1)'(128);
  localparam logic signed [DATA_WIDTH:0] TMAX = (DATA_WIDTH+1)'(255);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, SETTLE, ADDR, LUT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   issue_cnt, res_cnt;
  logic            issue_fire, issue_last, res_take, res_last, accept;
  logic signed [DATA_WIDTH:0] acc_ext, t_val;
  logic [ADDR_WIDTH-1:0]      lut_sat;

  assign accept     = (state == IDLE) && start;
  assign issue_fire = (state == ISSUE) && mac_ready;
  assign issue_last = issue_fire && (issue_cnt == N_CNT - 1'b1);
  // Results are only counted while an evaluation is collecting them; stray
  // or post-reset results from the multiplier pipeline fall through here.
  assign res_take   = (state == ISSUE || state == DRAIN) && res_valid && (res_cnt < N_CNT);
  assign res_last   = res_take && (res_cnt == N_CNT - 1'b1);

  // Q8.8 sum -> Q8.4 step, re-centred on address 128, clamped to the table.
  assign acc_ext = {acc_data[DATA_WIDTH-1], acc_data};
  assign t_val   = (acc_ext >>> 4) + BIAS;
  always_comb begin
    lut_sat = t_val[ADDR_WIDTH-1:0];
    if (t_val[DATA_WIDTH])  lut_sat = '0;
    else if (t_val > TMAX)  lut_sat = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    mac_valid = 1'b0;
    acc_en    = res_take;
    done      = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = ISSUE;
      ISSUE: begin
        mac_valid = 1'b1;
        // A zero-latency multiplier can finish both counts on the same edge.
        if (issue_last) state_nxt = res_last ? SETTLE : DRAIN;
      end
      DRAIN:  if (res_last) state_nxt = SETTLE;
      // One idle cycle so the accumulator registers the final product.
      SETTLE: state_nxt = ADDR;
      ADDR:   state_nxt = LUT;
      LUT: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt     <= '0;
      res_cnt       <= '0;
      in_idx        <= '0;
      acc_clr       <= 1'b0;
      lut_addr      <= '0;
      output_neuron <= '0;
    end else begin
      acc_clr <= accept;
      if (accept) begin
        issue_cnt <= '0;
        res_cnt   <= '0;
        in_idx    <= '0;
      end else begin
        if (issue_fire) begin
          issue_cnt <= issue_cnt + 1'b1;
          // Leave the address parked on the last operand rather than wrapping.
          if (!issue_last) in_idx <= in_idx + 1'b1;
        end
        if (res_take) res_cnt <= res_cnt + 1'b1;
      end
      if (state == ADDR) lut_addr      <= lut_sat;
      if (state == LUT)  output_neuron <= lut_data;
    end
  end

endmodule
